mult_arbiter: RTL and testbench

Round-robin arbiter that shares one fully pipelined unsigned 32x32 multiplier among NREQ requesters. Grants at most one request per cycle and captures the winner's operands into the multiplier. Carries the winner's ID through a tag pipeline that runs alongside the multiplier, and returns each 64-bit product to its originating requester with a one-hot valid. Sits between the DSP client blocks and the single shared multiplier pipeline.

---
 rtl/mult_arb_pkg.sv | 23 ++
 rtl/mult_pipe.sv | 56 +++++
 rtl/mult_arbiter.sv | 124 ++++++++++++
 tb/tb_mult_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared constants and types for the round-robin multiplier arbiter.
package mult_arb_pkg;

  localparam int MULT_W   = 32;
  localparam int RES_W    = 64;
  localparam int MULT_LAT = 7;
  localparam int ID_W     = 3;

  // One tag pipeline entry: travels alongside the multiplier data path.
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  // Requester index plus one, wrapping at nreq.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id, input int nreq);
    if (int'(id) == nreq - 1) begin
      return '0;
    end
    return id + ID_W'(1);
  endfunction

endpackage

// File: rtl/mult_pipe.sv
// Unsigned 32x32 -> 64 multiplier, fully pipelined: one operand register stage
// followed by six product register stages (7 cycles from capture to output).
// Operand registers only load on a valid issue, so when the pipe is idle every
// stage settles to the last product and the output holds its last value.
module mult_pipe
  import mult_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [MULT_W-1:0] a,
  input  logic [MULT_W-1:0] b,
  output logic [RES_W-1:0]  prod
);

  localparam int NSTG = MULT_LAT - 1;

  logic [MULT_W-1:0] a_q, a_d;
  logic [MULT_W-1:0] b_q, b_d;
  logic [RES_W-1:0]  prod_q [NSTG];
  logic [RES_W-1:0]  prod_d [NSTG];

  // Operand capture on issue, multiply, then shift the product down the stages.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (in_vld) begin
      a_d = a;
      b_d = b;
    end
    prod_d[0] = RES_W'(a_q) * RES_W'(b_q);
    for (int i = 1; i < NSTG; i++) begin
      prod_d[i] = prod_q[i-1];
    end
  end

  // Pipeline registers; reset clears everything so the output reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      for (int i = 0; i < NSTG; i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      for (int i = 0; i < NSTG; i++) begin
        prod_q[i] <= prod_d[i];
      end
    end
  end

  assign prod = prod_q[NSTG-1];

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter in front of one shared pipelined multiplier.
// Grants at most one requester per cycle, tracks the winner's ID through a tag
// pipeline matched to the multiplier latency, and returns each product with a
// one-hot valid naming its requester.
// Optional feature: define MULT_ARB_PRIO0_EN to give requester 0 absolute
// priority (it never moves the pointer; the rest stay round-robin).
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        REQ,
  input  logic [NREQ*MULT_W-1:0] A,
  input  logic [NREQ*MULT_W-1:0] B,
  output logic [NREQ-1:0]        ACK,
  output logic [RES_W-1:0]       RES,
  output logic [NREQ-1:0]        RES_VLD,
  output logic [3:0]             INFLIGHT,
  output logic                   BUSY
);

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [3:0]        infl_q, infl_d;
  tag_t              tag_q [MULT_LAT];
  tag_t              tag_d [MULT_LAT];

  logic              grant_vld;
  logic              prio0_hit;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   idx;
  logic [MULT_W-1:0] op_a, op_b;
  logic              retire;

  // Arbitration: first asserted request searching upward from the pointer.
  // Under the priority option requester 0 wins outright; when it is idle its
  // REQ bit is low, so the ordinary search naturally skips it.
  always_comb begin
    grant_vld = 1'b0;
    prio0_hit = 1'b0;
    grant_id  = '0;
    idx       = '0;
    if (!rst) begin
`ifdef MULT_ARB_PRIO0_EN
      if (REQ[0]) begin
        grant_vld = 1'b1;
        prio0_hit = 1'b1;
      end
`endif
      for (int k = 0; k < NREQ; k++) begin
        idx = ID_W'((int'(ptr_q) + k) % NREQ);
        if (!grant_vld && (|(REQ & (NREQ'(1) << idx)))) begin
          grant_vld = 1'b1;
          grant_id  = idx;
        end
      end
    end
  end

  // Winner's operand select.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_id == ID_W'(k)) begin
        op_a = A[k*MULT_W +: MULT_W];
        op_b = B[k*MULT_W +: MULT_W];
      end
    end
  end

  // Next-state: pointer advance, tag shift, in-flight count.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld && !prio0_hit) begin
      ptr_d = next_id(grant_id, NREQ);
    end
    tag_d[0].valid = grant_vld;
    tag_d[0].id    = grant_id;
    for (int i = 1; i < MULT_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    retire = tag_q[MULT_LAT-1].valid;
    infl_d = infl_q;
    case ({grant_vld, retire})
      2'b10:   infl_d = infl_q + 4'd1;
      2'b01:   infl_d = infl_q - 4'd1;
      default: infl_d = infl_q;
    endcase
  end

  // State registers; reset drops all in-flight tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      infl_q <= '0;
      for (int i = 0; i < MULT_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      ptr_q  <= ptr_d;
      infl_q <= infl_d;
      for (int i = 0; i < MULT_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  mult_pipe u_mult_pipe (
    .clk    (clk),
    .rst    (rst),
    .in_vld (grant_vld),
    .a      (op_a),
    .b      (op_b),
    .prod   (RES)
  );

  assign ACK      = grant_vld ? (NREQ'(1) << grant_id) : '0;
  assign RES_VLD  = retire ? (NREQ'(1) << tag_q[MULT_LAT-1].id) : '0;
  assign INFLIGHT = infl_q;
  assign BUSY     = (infl_q != 4'd0);

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter (NREQ=4). Inputs change 1ns after the rising
// edge; outputs are sampled 1ns later, well away from the next edge.
module tb_mult_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   REQ = '0;
  logic [NREQ*32-1:0] A  = '0;
  logic [NREQ*32-1:0] B  = '0;
  logic [NREQ-1:0]   ACK;
  logic [63:0]       RES;
  logic [NREQ-1:0]   RES_VLD;
  logic [3:0]        INFLIGHT;
  logic              BUSY;

  int n_vec = 0;
  int n_err = 0;

  mult_arbiter #(.NREQ(NREQ)) dut (
    .clk      (clk),
    .rst      (rst),
    .REQ      (REQ),
    .A        (A),
    .B        (B),
    .ACK      (ACK),
    .RES      (RES),
    .RES_VLD  (RES_VLD),
    .INFLIGHT (INFLIGHT),
    .BUSY     (BUSY)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    A[i*32 +: 32] = a;
    B[i*32 +: 32] = b;
  endtask

  initial begin
    int exp_infl;

    // Reset held with all requests high: ACK masked, outputs at reset values.
    rst = 1'b1;
    REQ = 4'b1111;
    tick();
    tick();
    settle();
    chk("rst_ack", ACK, 0);
    chk("rst_res", RES, 0);
    chk("rst_vld", RES_VLD, 0);
    chk("rst_infl", INFLIGHT, 0);
    chk("rst_busy", BUSY, 0);

    // Single op from requester 2 in the first cycle after reset.
    tick();
    rst = 1'b0;
    REQ = 4'b0100;
    set_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    settle();
    chk("single_ack", ACK, 4'b0100);
    for (int k = 1; k <= 8; k++) begin
      tick();
      REQ = '0;
      settle();
      chk("single_infl", INFLIGHT, (k <= 7) ? 64'd1 : 64'd0);
      chk("single_vld", RES_VLD, (k == 7) ? 64'h4 : 64'h0);
      if (k >= 7) chk("single_res", RES, 64'hFFFF_FFFE_0000_0001);
    end

`ifndef MULT_ARB_PRIO0_EN
    // Pointer wrap: last grant went to 2, so 3 is searched before 0.
    tick();
    REQ = 4'b1001;
    set_op(0, 32'd5, 32'd6);
    set_op(3, 32'd7, 32'd8);
    settle();
    chk("wrap_first", ACK, 4'b1000);
    tick();
    REQ = 4'b0001;
    settle();
    chk("wrap_second", ACK, 4'b0001);
    tick();
    REQ = '0;
    settle();
    chk("wrap_infl", INFLIGHT, 2);
    for (int k = 3; k <= 6; k++) tick();
    tick();
    settle();
    chk("wrap_vld3", RES_VLD, 4'b1000);
    chk("wrap_res3", RES, 64'd56);
    tick();
    settle();
    chk("wrap_vld0", RES_VLD, 4'b0001);
    chk("wrap_res0", RES, 64'd30);

    // Full contention from a fresh pointer: grants rotate 0,1,2,3,...
    tick();
    rst = 1'b1;
    REQ = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 1), 32'd10);
    for (int k = 0; k < 16; k++) begin
      if (k != 0) tick();
      REQ = (k < 8) ? 4'b1111 : 4'b0000;
      settle();
      chk("rr_ack", ACK, (k < 8) ? (64'd1 << (k % 4)) : 64'd0);
      exp_infl = ((k < 8) ? k : 8) - ((k > 7) ? (k - 7) : 0);
      chk("rr_infl", INFLIGHT, 64'(exp_infl));
      if (k >= 7 && k <= 14) begin
        chk("rr_vld", RES_VLD, 64'd1 << ((k - 7) % 4));
        chk("rr_res", RES, 64'(10 * (((k - 7) % 4) + 1)));
      end else begin
        chk("rr_vld_idle", RES_VLD, 0);
      end
    end
`endif

    // Reset mid-operation: three ops in flight are dropped.
    tick();
    REQ = 4'b0001;
    settle();
    chk("rm_ack0", ACK, 4'b0001);
    tick();
    REQ = 4'b0010;
    settle();
    chk("rm_ack1", ACK, 4'b0010);
    tick();
    REQ = 4'b0100;
    settle();
    chk("rm_ack2", ACK, 4'b0100);
    tick();
    REQ = '0;
    tick();
    rst = 1'b1;
    REQ = 4'b1001;
    settle();
    chk("rm_ack_masked", ACK, 0);
    chk("rm_infl_pre", INFLIGHT, 3);
    tick();
    rst = 1'b0;
    set_op(0, 32'h8000_0000, 32'd2);
    set_op(3, 32'h0000_0000, 32'hFFFF_FFFF);
    settle();
    chk("rm_ack_after", ACK, 4'b0001);
    chk("rm_infl_post", INFLIGHT, 0);
    chk("rm_res_post", RES, 0);
    chk("rm_vld_post", RES_VLD, 0);
    tick();
    REQ = 4'b1000;
    settle();
    chk("rm_ack3", ACK, 4'b1000);
    for (int k = 7; k <= 14; k++) begin
      tick();
      REQ = '0;
      settle();
      chk("rm_vld", RES_VLD, (k == 12) ? 64'h1 : ((k == 13) ? 64'h8 : 64'h0));
      if (k == 12) chk("bound_res_msb", RES, 64'h0000_0001_0000_0000);
      if (k == 13) chk("bound_res_zero", RES, 64'h0);
    end
    chk("rm_busy_end", BUSY, 0);

`ifdef MULT_ARB_PRIO0_EN
    // Requester 0 always wins; the others rotate once it drops out.
    for (int k = 0; k < 4; k++) begin
      tick();
      REQ = 4'b1111;
      settle();
      chk("prio_ack0", ACK, 4'b0001);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      REQ = 4'b1110;
      settle();
      chk("prio_rot", ACK, 64'd2 << k);
    end
`endif

    tick();
    REQ = '0;
    for (int k = 0; k < 10; k++) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
